dequantizer: RTL and testbench

Receive-side inverse of the block IQ quantizer. It takes the compressed stream of 2×QUANTIZATION_BITWIDTH IQ words and comma words, and recovers the per-block scaling factor from each comma word. It expands each sample back to INPUT_DATA_BITWIDTH by left-alignment and an arithmetic right shift, and tracks block framing with a small lock state machine. It sits between the fronthaul deframer and the downstream DSP chain.

---
 rtl/dequantizer_pkg.sv | 31 +++
 rtl/dequantizer_if.sv | 31 +++
 rtl/dequantizer_iq_expand.sv | 29 ++
 rtl/dequantizer.sv | 123 ++++++++++++
 tb/tb_dequantizer.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/dequantizer_pkg.sv
// rtl/dequantizer_pkg.sv - shared widths, framing constants and lock-state type for the dequantizer
//
// Purpose: one place for the stream widths, block length, shift-exponent width,
// the HUNT/LOCKED state type and the shift clamp helper.
// Ports: none (package).
package dequantizer_pkg;

    localparam int INPUT_DATA_BITWIDTH     = 32;
    localparam int QUANTIZATION_BITWIDTH   = 12;
    localparam int SCALING_FACTOR_BITWIDTH = 12;
    localparam int BLOCK_LEN               = 16;
    localparam int SHIFT_BITS              = 4;

    // Width of one reconstructed component (I or Q).
    localparam int HALF_BITWIDTH = INPUT_DATA_BITWIDTH / 2;

    // The counter must be able to hold BLOCK_LEN itself, which marks "header due".
    localparam int CNT_BITS = $clog2(BLOCK_LEN + 1);

    typedef enum logic [0:0] {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } deq_state_t;

    // Shifting by H or more would push every magnitude bit out; saturate at H-1
    // so the result is still a pure sign extension of the MSB.
    function automatic int unsigned clamp_shift(input int unsigned shift);
        return (shift > HALF_BITWIDTH - 1) ? HALF_BITWIDTH - 1 : shift;
    endfunction

endpackage

// File: rtl/dequantizer_if.sv
// rtl/dequantizer_if.sv - compressed-input / expanded-output signal bundle for the dequantizer
//
// Purpose: groups the deframer-side input word and the DSP-side output sample
// with its framing status.
// master modport: drives validIn, commaIn, quantizedData; observes the outputs.
// slave modport : the dequantizer itself.
interface dequantizer_if
    import dequantizer_pkg::*;
();

    logic                                 validIn;
    logic                                 commaIn;
    logic [2*QUANTIZATION_BITWIDTH-1:0]   quantizedData;
    logic                                 validOut;
    logic                                 commaOut;
    logic [INPUT_DATA_BITWIDTH-1:0]       dataOut;
    logic [SCALING_FACTOR_BITWIDTH-1:0]   scalingFactorOut;
    logic                                 locked;
    logic                                 syncErr;

    modport master (
        output validIn, commaIn, quantizedData,
        input  validOut, commaOut, dataOut, scalingFactorOut, locked, syncErr
    );

    modport slave (
        input  validIn, commaIn, quantizedData,
        output validOut, commaOut, dataOut, scalingFactorOut, locked, syncErr
    );

endinterface

// File: rtl/dequantizer_iq_expand.sv
// rtl/dequantizer_iq_expand.sv - combinational left-align and arithmetic shift of one IQ component
//
// Purpose: the two halves of the per-component expansion. Alignment feeds the
// first pipeline register, the shift works on the registered aligned value.
// Ports:
//   q_i       compressed component (two's complement)
//   aligned_o q_i placed in the top bits of an H-bit field, zeros below
//   aligned_i registered aligned value
//   shift_i   block shift exponent
//   shifted_o aligned_i arithmetically shifted right by the clamped exponent
module iq_expand
    import dequantizer_pkg::*;
(
    input  logic [QUANTIZATION_BITWIDTH-1:0] q_i,
    output logic [HALF_BITWIDTH-1:0]         aligned_o,
    input  logic [HALF_BITWIDTH-1:0]         aligned_i,
    input  logic [SHIFT_BITS-1:0]            shift_i,
    output logic [HALF_BITWIDTH-1:0]         shifted_o
);

    localparam int PAD_BITS = HALF_BITWIDTH - QUANTIZATION_BITWIDTH;

    int unsigned shamt;

    assign aligned_o = HALF_BITWIDTH'(q_i) << PAD_BITS;
    assign shamt     = clamp_shift(32'(shift_i));
    assign shifted_o = $signed(aligned_i) >>> shamt;

endmodule

// File: rtl/dequantizer.sv
// rtl/dequantizer.sv - block IQ dequantizer with comma-based framing lock
//
// Purpose: consumes comma (block header) and compressed sample words, keeps the
// block scaling factor, expands each sample to full width and tracks framing.
// Ports:
//   clk  clock, all logic on posedge
//   rst  synchronous active-high reset
//   bus  dequantizer_if.slave: input word, output sample, locked, syncErr
// Latency is two cycles: stage 1 holds aligned components, shift, sf and the
// first-of-block tag; stage 2 holds the shifted result.
module dequantizer
    import dequantizer_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    dequantizer_if.slave  bus
);

    localparam logic [CNT_BITS-1:0] CNT_FULL = CNT_BITS'(BLOCK_LEN);

    deq_state_t                          state_q;
    logic [CNT_BITS-1:0]                 cnt_q;
    logic [SCALING_FACTOR_BITWIDTH-1:0]  sf_q;

    logic                                s1_valid_q;
    logic                                s1_comma_q;
    logic [HALF_BITWIDTH-1:0]            s1_i_q;
    logic [HALF_BITWIDTH-1:0]            s1_qc_q;
    logic [SHIFT_BITS-1:0]               s1_shift_q;
    logic [SCALING_FACTOR_BITWIDTH-1:0]  s1_sf_q;

    logic                                valid_out_q;
    logic                                comma_out_q;
    logic [INPUT_DATA_BITWIDTH-1:0]      data_out_q;
    logic [SCALING_FACTOR_BITWIDTH-1:0]  sf_out_q;
    logic                                sync_err_q;

    logic [HALF_BITWIDTH-1:0]            aligned_i_d;
    logic [HALF_BITWIDTH-1:0]            aligned_q_d;
    logic [HALF_BITWIDTH-1:0]            shifted_i_d;
    logic [HALF_BITWIDTH-1:0]            shifted_q_d;

    iq_expand u_expand_i (
        .q_i       (bus.quantizedData[2*QUANTIZATION_BITWIDTH-1:QUANTIZATION_BITWIDTH]),
        .aligned_o (aligned_i_d),
        .aligned_i (s1_i_q),
        .shift_i   (s1_shift_q),
        .shifted_o (shifted_i_d)
    );

    iq_expand u_expand_q (
        .q_i       (bus.quantizedData[QUANTIZATION_BITWIDTH-1:0]),
        .aligned_o (aligned_q_d),
        .aligned_i (s1_qc_q),
        .shift_i   (s1_shift_q),
        .shifted_o (shifted_q_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            cnt_q       <= '0;
            sf_q        <= '0;
            s1_valid_q  <= 1'b0;
            s1_comma_q  <= 1'b0;
            s1_i_q      <= '0;
            s1_qc_q     <= '0;
            s1_shift_q  <= '0;
            s1_sf_q     <= '0;
            valid_out_q <= 1'b0;
            comma_out_q <= 1'b0;
            data_out_q  <= '0;
            sf_out_q    <= '0;
            sync_err_q  <= 1'b0;
        end else begin
            s1_valid_q <= 1'b0;
            sync_err_q <= 1'b0;

            if (bus.validIn) begin
                if (bus.commaIn) begin
                    // A header always (re)establishes framing; arriving before
                    // the block is complete is flagged but still honoured.
                    sf_q    <= bus.quantizedData[SCALING_FACTOR_BITWIDTH-1:0];
                    cnt_q   <= '0;
                    state_q <= LOCKED;
                    if (state_q == LOCKED && cnt_q != CNT_FULL) begin
                        sync_err_q <= 1'b1;
                    end
                end else if (state_q == LOCKED) begin
                    if (cnt_q == CNT_FULL) begin
                        // Block overran without a header: lose lock, drop the word.
                        sync_err_q <= 1'b1;
                        state_q    <= HUNT;
                        cnt_q      <= '0;
                    end else begin
                        s1_valid_q <= 1'b1;
                        s1_comma_q <= (cnt_q == '0);
                        s1_i_q     <= aligned_i_d;
                        s1_qc_q    <= aligned_q_d;
                        s1_shift_q <= sf_q[SHIFT_BITS-1:0];
                        s1_sf_q    <= sf_q;
                        cnt_q      <= cnt_q + CNT_BITS'(1);
                    end
                end
            end

            valid_out_q <= s1_valid_q;
            comma_out_q <= s1_valid_q & s1_comma_q;
            if (s1_valid_q) begin
                data_out_q <= {shifted_i_d, shifted_q_d};
                sf_out_q   <= s1_sf_q;
            end
        end
    end

    assign bus.validOut         = valid_out_q;
    assign bus.commaOut         = comma_out_q;
    assign bus.dataOut          = data_out_q;
    assign bus.scalingFactorOut = sf_out_q;
    assign bus.locked           = (state_q == LOCKED);
    assign bus.syncErr          = sync_err_q;

endmodule

// File: tb/tb_dequantizer.sv
// tb/tb_dequantizer.sv - scoreboard bench for the dequantizer
module tb_dequantizer;
    import dequantizer_pkg::*;

    typedef struct packed {
        logic        comma;
        logic [31:0] data;
        logic [11:0] sf;
    } exp_t;

    logic clk;
    logic rst;
    dequantizer_if bus ();

    dequantizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb[$];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          err_seen = 0;
    logic        first_q  = 1'b0;
    logic [11:0] cur_sf   = '0;
    int          seed_k   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected entry per presented output sample.
    always @(negedge clk) begin
        exp_t e;
        if (bus.syncErr === 1'b1) err_seen++;
        if (bus.validOut === 1'b1) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got data %h with no expected entry", bus.dataOut);
            end else begin
                e = sb.pop_front();
                chk("dataOut", bus.dataOut, e.data);
                chk("commaOut", 32'(bus.commaOut), 32'(e.comma));
                chk("scalingFactorOut", 32'(bus.scalingFactorOut), 32'(e.sf));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d expected outputs pending", sb.size());
        $fatal(1);
    end

    function automatic logic [15:0] mexp(input logic [11:0] q, input logic [3:0] sh);
        logic signed [15:0] a;
        a = {q, 4'h0};
        return 16'(a >>> sh);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic c, input logic [23:0] d);
        bus.validIn       = 1'b1;
        bus.commaIn       = c;
        bus.quantizedData = d;
        tick();
        bus.validIn       = 1'b0;
        bus.commaIn       = 1'b0;
    endtask

    task automatic comma(input logic [11:0] sf);
        drive(1'b1, {12'h000, sf});
        cur_sf  = sf;
        first_q = 1'b1;
    endtask

    task automatic sample_exp(input logic [11:0] i, input logic [11:0] q, input logic [31:0] data);
        sb.push_back('{comma: first_q, data: data, sf: cur_sf});
        first_q = 1'b0;
        drive(1'b0, {i, q});
    endtask

    task automatic sample_auto();
        logic [11:0] i;
        logic [11:0] q;
        seed_k++;
        i = 12'(seed_k * 397 + 5);
        q = 12'(seed_k * 1123 + 2048);
        sample_exp(i, q, {mexp(i, cur_sf[3:0]), mexp(q, cur_sf[3:0])});
    endtask

    task automatic sample_drop(input logic [11:0] i, input logic [11:0] q);
        drive(1'b0, {i, q});
    endtask

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) sample_auto();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_validOut"}, 32'(bus.validOut), 32'h0);
        chk({tag, "_commaOut"}, 32'(bus.commaOut), 32'h0);
        chk({tag, "_dataOut"}, bus.dataOut, 32'h0);
        chk({tag, "_sfOut"}, 32'(bus.scalingFactorOut), 32'h0);
        chk({tag, "_locked"}, 32'(bus.locked), 32'h0);
        chk({tag, "_syncErr"}, 32'(bus.syncErr), 32'h0);
    endtask

    initial begin
        rst               = 1'b1;
        bus.validIn       = 1'b0;
        bus.commaIn       = 1'b0;
        bus.quantizedData = '0;
        repeat (3) tick();
        check_reset_values("reset");
        rst = 1'b0;
        tick();

        // HUNT discards samples
        sample_drop(12'h123, 12'h456);
        chk("hunt_locked", 32'(bus.locked), 32'h0);

        // Lock and basic expand, then directed shifts
        comma(12'h004);
        chk("lock_after_comma", 32'(bus.locked), 32'h1);
        sample_exp(12'h7FF, 12'h800, 32'h07FF_F800);
        fill(15);
        comma(12'h000);
        sample_exp(12'h001, 12'h001, 32'h0010_0010);
        fill(15);
        comma(12'h003);
        sample_exp(12'h800, 12'h800, 32'hF000_F000);
        fill(15);
        comma(12'hA53);
        sample_exp(12'h800, 12'h7FF, 32'hF000_0FFE);
        fill(15);

        // Three full blocks with idle gaps
        for (int b = 0; b < 3; b++) begin
            comma(12'(12'h0B1 + b * 12'h111));
            if (b == 1) repeat (2) tick();
            for (int s = 0; s < 16; s++) begin
                if (s % 4 == 2) repeat (1 + s % 3) tick();
                sample_auto();
            end
        end
        repeat (4) tick();
        chk("full_blocks_no_syncErr", 32'(err_seen), 32'd0);

        // Early comma after 10 samples
        comma(12'h002);
        fill(10);
        comma(12'h005);
        chk("early_syncErr_pulse", 32'(bus.syncErr), 32'h1);
        chk("early_locked", 32'(bus.locked), 32'h1);
        sample_exp(12'h400, 12'hC00, 32'h0200_FE00);
        fill(15);
        repeat (4) tick();
        chk("early_err_count", 32'(err_seen), 32'd1);

        // Missing comma: 17th sample
        sample_drop(12'h555, 12'h2AA);
        chk("missing_syncErr_pulse", 32'(bus.syncErr), 32'h1);
        chk("missing_locked", 32'(bus.locked), 32'h0);
        for (int k = 0; k < 3; k++) sample_drop(12'(k + 1), 12'(k + 2));
        chk("missing_hunt_locked", 32'(bus.locked), 32'h0);
        repeat (4) tick();
        chk("missing_err_count", 32'(err_seen), 32'd2);

        // Reset mid-block after 5 samples; the 5th is still in flight
        comma(12'h001);
        sample_exp(12'h100, 12'hF00, 32'h0800_F800);
        fill(3);
        sample_drop(12'h3C3, 12'h0F0);
        rst = 1'b1;
        tick();
        check_reset_values("midrst");
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) sample_drop(12'(k + 7), 12'(k + 9));
        chk("post_rst_locked", 32'(bus.locked), 32'h0);
        repeat (3) tick();
        comma(12'h007);
        chk("relock", 32'(bus.locked), 32'h1);
        sample_exp(12'h7FF, 12'h001, 32'h00FF_0000);

        repeat (6) tick();
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        chk("final_err_count", 32'(err_seen), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
